// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin scheduler sharing one UART transmitter among NREQ byte requesters,
//           with per-requester frame lock so multi-byte frames are never interleaved.
// Latency : req sampled in IDLE at edge N -> ack/tx_start during cycle N+1; next start >= 2 cycles after tx_done_tick.
// Backpressure: req is a level held until ack; while a byte is in flight (busy) no new grant is made.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   req/din/lock      per-requester request level, packed bytes, frame lock
//   ack               one-hot 1-cycle accept pulse
//   tx_start/tx_din   start pulse and byte towards the transmitter
//   tx_done_tick      completion pulse from the transmitter
//   busy/owner        transfer in progress / index of last granted requester
module uart_tx_arbiter #(
    parameter int NREQ = 4,
    parameter int DBIT = 8,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DBIT-1:0] din,
    input  logic [NREQ-1:0]      lock,
    output logic [NREQ-1:0]      ack,
    output logic                 tx_start,
    output logic [DBIT-1:0]      tx_din,
    input  logic                 tx_done_tick,
    output logic                 busy,
    output logic [IDW-1:0]       owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              tx_start_q, tx_start_d;
    logic [DBIT-1:0]   tx_din_q, tx_din_d;
    logic              busy_q, busy_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              owner_locked_q, owner_locked_d;

    logic [NREQ-1:0]   owner_mask;
    logic              eff_locked;
    logic [NREQ-1:0]   elig;
    logic              win_vld;
    logic [IDW-1:0]    win_idx;
    logic [IDW-1:0]    cand;

    assign owner_mask = NREQ'(1) << owner_q;

    // Winner search. The lock only binds while the owner still holds its lock
    // input, which folds the "clear in IDLE when lock drops" rule into the
    // same-cycle eligibility decision. NREQ is a power of two, so the circular
    // index wraps by plain truncation to IDW bits.
    always_comb begin
        eff_locked = owner_locked_q & lock[owner_q];
        elig       = eff_locked ? (req & owner_mask) : req;
        win_vld    = 1'b0;
        win_idx    = '0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = rr_ptr_q + IDW'(i);
            if (!win_vld && elig[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ack_d          = '0;
        tx_start_d     = 1'b0;
        tx_din_d       = tx_din_q;
        busy_d         = busy_q;
        owner_d        = owner_q;
        rr_ptr_d       = rr_ptr_q;
        owner_locked_d = owner_locked_q;
        case (state_q)
            IDLE: begin
                if (!lock[owner_q]) begin
                    owner_locked_d = 1'b0;
                end
                if (win_vld) begin
                    // Pulses are loaded here so they are visible, registered,
                    // for exactly the single SEND cycle.
                    state_d    = SEND;
                    owner_d    = win_idx;
                    rr_ptr_d   = win_idx + IDW'(1);
                    tx_din_d   = din[win_idx*DBIT +: DBIT];
                    ack_d      = NREQ'(1) << win_idx;
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done_tick) begin
                    state_d        = IDLE;
                    owner_locked_d = lock[owner_q];
                    busy_d         = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            ack_q          <= '0;
            tx_start_q     <= 1'b0;
            tx_din_q       <= '0;
            busy_q         <= 1'b0;
            owner_q        <= '0;
            rr_ptr_q       <= '0;
            owner_locked_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ack_q          <= ack_d;
            tx_start_q     <= tx_start_d;
            tx_din_q       <= tx_din_d;
            busy_q         <= busy_d;
            owner_q        <= owner_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_locked_q <= owner_locked_d;
        end
    end

    assign ack      = ack_q;
    assign tx_start = tx_start_q;
    assign tx_din   = tx_din_q;
    assign busy     = busy_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose : self-checking bench for uart_tx_arbiter with a transaction-level arbiter model and scoreboard.
// Latency : expected grants carry the cycle in which ack/tx_start must appear.
// Backpressure: requesters are byte queues held on req until ack; a transmitter model answers each start with a done tick.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int DBIT = 8;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DBIT-1:0] din = '0;
    logic [NREQ-1:0]      lock = '0;
    logic                 tx_done_tick = 1'b0;
    logic [NREQ-1:0]      ack;
    logic                 tx_start;
    logic [DBIT-1:0]      tx_din;
    logic                 busy;
    logic [IDW-1:0]       owner;

    uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT)) dut (
        .clk(clk), .reset(reset), .req(req), .din(din), .lock(lock),
        .ack(ack), .tx_start(tx_start), .tx_din(tx_din),
        .tx_done_tick(tx_done_tick), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] dat;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         grant_log[$];
    logic [8:0] rq[NREQ][$];   // {more_bytes_follow_in_frame, byte}

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cyc = -1;
    int xcnt = 0;
    bit gap_chk = 1'b0;
    bit spur_en = 1'b0;
    logic [NREQ-1:0] pulse_r = '0;
    logic [NREQ-1:0] lock_r = '0;
    logic [7:0]      pdat = '0;

    // model state
    int m_st = 0;          // 0 free, 1 start cycle, 2 byte on the wire
    int m_ptr = 0;
    int m_owner = 0;
    bit m_locked = 1'b0;
    bit m_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: transfer-level view of the scheduling rules.
    initial begin : model
        logic [NREQ-1:0] elig;
        int win;
        int c;
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_st = 0; m_ptr = 0; m_owner = 0; m_locked = 1'b0; m_busy = 1'b0;
                exp_q.delete();
            end else begin
                if (m_st == 0) begin
                    if (m_locked && !lock[m_owner]) m_locked = 1'b0;
                    elig = req;
                    if (m_locked) elig = req & (NREQ'(1) << m_owner);
                    win = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        c = (m_ptr + k) % NREQ;
                        if (win < 0 && elig[c]) win = c;
                    end
                    if (win >= 0) begin
                        e.idx = win;
                        e.dat = din[win*DBIT +: DBIT];
                        e.cyc = cyc + 1;
                        exp_q.push_back(e);
                        m_owner = win;
                        m_ptr = (win + 1) % NREQ;
                        m_st = 1;
                    end
                end else if (m_st == 1) begin
                    m_st = 2;
                end else if (tx_done_tick) begin
                    m_locked = lock[m_owner];
                    m_st = 0;
                end
                m_busy = (m_st != 0);
                cyc++;
            end
        end
    end

    // Monitor: compares every presented grant against the scoreboard.
    initial begin : monitor
        exp_t e;
        int gi;
        logic [7:0] last_dat;
        last_dat = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_dat = '0;
            end else begin
                chk("busy", busy, m_busy);
                if (tx_start || ack != '0) begin
                    gi = -1;
                    for (int i = 0; i < NREQ; i++) if (ack[i]) gi = i;
                    grant_log.push_back(gi);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", {ack, 3'b0, tx_start}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack", ack, NREQ'(1) << e.idx);
                        chk("tx_start", tx_start, 1);
                        chk("tx_din", tx_din, e.dat);
                        chk("owner", owner, e.idx);
                        chk("grant_cycle", cyc, e.cyc);
                        if (gap_chk && done_cyc >= 0) chk("done_to_start_gap", cyc - done_cyc, 2);
                        last_dat = e.dat;
                    end
                end else begin
                    chk("tx_din_hold", tx_din, last_dat);
                end
            end
        end
    end

    // One clock of environment: transmitter model and requester queues.
    task automatic step();
        logic [NREQ-1:0] a_seen;
        logic s_seen;
        logic [8:0] tmp;
        @(negedge clk);
        a_seen = ack;
        s_seen = tx_start;
        @(posedge clk);
        #1;
        tx_done_tick = 1'b0;
        if (reset) begin
            xcnt = 0;
            lock_r = '0;
            for (int i = 0; i < NREQ; i++) rq[i].delete();
        end else begin
            if (s_seen) xcnt = $urandom_range(3, 9);
            else if (xcnt > 0) begin
                xcnt--;
                if (xcnt == 0) begin
                    tx_done_tick = 1'b1;
                    done_cyc = cyc;
                end
            end else if (spur_en && $urandom_range(0, 7) == 0) tx_done_tick = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (a_seen[i] && rq[i].size() > 0) begin
                    tmp = rq[i].pop_front();
                    lock_r[i] = tmp[8];
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (rq[i].size() > 0) | pulse_r[i];
            din[i*DBIT +: DBIT] = (rq[i].size() > 0) ? rq[i][0][7:0] : pdat;
            lock[i] = lock_r[i];
        end
    endtask

    task automatic wait_grants(input int n, input int budget);
        int t;
        t = 0;
        while (grant_log.size() < n && t < budget) begin
            step();
            t++;
        end
        chk("grant_count", grant_log.size(), n);
    endtask

    function automatic int pending();
        int p;
        p = exp_q.size() + xcnt + (busy ? 1 : 0);
        for (int i = 0; i < NREQ; i++) p += rq[i].size();
        return p;
    endfunction

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (pending() != 0 && t < budget) begin
            step();
            t++;
        end
        step();
        step();
        chk("drained", pending(), 0);
    endtask

    task automatic push_frame(input int r, input int len);
        for (int b = 0; b < len; b++)
            rq[r].push_back({(b < len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255))});
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int mark;
        int r;
        int exp_rr [12];
        int exp_lk [5];
        exp_lk = '{2, 2, 2, 3, 0};
        for (int k = 0; k < 12; k++) exp_rr[k] = k % NREQ;

        repeat (3) step();
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_din", tx_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // First grant after reset is 0xA5 from requester 0, then fairness.
        gap_chk = 1'b1;
        done_cyc = -1;
        mark = grant_log.size();
        rq[0].push_back({1'b0, 8'hA5});
        for (int i = 0; i < NREQ; i++) push_frame(i, (i == 0) ? 2 : 3);
        for (int i = 0; i < NREQ; i++) rq[i][rq[i].size()-1][8] = 1'b0;
        for (int i = 0; i < NREQ; i++) for (int b = 0; b < rq[i].size(); b++) rq[i][b][8] = 1'b0;
        wait_grants(mark + 12, 600);
        for (int k = 0; k < 12; k++)
            if (mark + k < grant_log.size()) chk("rr_order", grant_log[mark + k], exp_rr[k]);
        wait_idle(300);
        gap_chk = 1'b0;

        // Frame lock: requester 2 sends three bytes while 0 and 3 wait.
        mark = grant_log.size();
        push_frame(2, 3);
        wait_grants(mark + 1, 50);
        push_frame(0, 1);
        push_frame(3, 1);
        wait_grants(mark + 5, 300);
        for (int k = 0; k < 5; k++)
            if (mark + k < grant_log.size()) chk("lock_order", grant_log[mark + k], exp_lk[k]);
        wait_idle(300);

        // Wrap 3 -> 0 with exact 2-cycle done-to-start spacing.
        gap_chk = 1'b1;
        done_cyc = -1;
        mark = grant_log.size();
        push_frame(3, 1);
        wait_grants(mark + 1, 50);
        push_frame(0, 1);
        wait_grants(mark + 2, 100);
        if (grant_log.size() >= mark + 2) begin
            chk("wrap_first", grant_log[mark], 3);
            chk("wrap_second", grant_log[mark + 1], 0);
        end
        wait_idle(300);
        gap_chk = 1'b0;

        // Request pulse while a byte is on the wire is never served.
        mark = grant_log.size();
        push_frame(0, 1);
        wait_grants(mark + 1, 50);
        step();
        pulse_r = 4'b0010;
        pdat = 8'h3C;
        step();
        pulse_r = '0;
        wait_idle(300);
        chk("withdrawn_grants", grant_log.size() - mark, 1);

        // Reset in the middle of a transfer.
        mark = grant_log.size();
        rq[1].push_back({1'b0, 8'h5A});
        wait_grants(mark + 1, 50);
        step();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_owner", owner, 0);
        chk("midrst_tx_din", tx_din, 0);
        step();
        step();
        reset = 1'b0;
        mark = grant_log.size();
        rq[3].push_back({1'b0, 8'hC3});
        wait_grants(mark + 1, 3);
        if (grant_log.size() > mark) chk("post_reset_grant", grant_log[mark], 3);
        wait_idle(300);

        // Randomized traffic with frames, locks and stray done ticks.
        spur_en = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, NREQ - 1);
                if (rq[r].size() < 6) push_frame(r, $urandom_range(1, 3));
            end
            step();
        end
        spur_en = 1'b0;
        wait_idle(3000);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` transmitter among NREQ byte requesters. It selects a requester, captures its byte, and pulses `tx_start` with the byte on `tx_din`. It then holds off further starts until the transmitter returns `tx_done_tick`. Per-requester lock inputs let a source send a multi-byte frame without interleaving. The block sits between client logic (command/response engines, debug printers) and the UART transmit path, and shares its clock and baud-tick domain.

## Interface
- `NREQ`, default 4: number of requesters; power of two, 2..8.
- `DBIT`, default 8: byte width; must equal the transmitter data width.
- `IDW`, default $clog2(NREQ): width of the `owner` field.

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester "byte available"; level; held until `ack`.
- `din`  in  NREQ*DBIT  packed bytes; requester i at bits [i*DBIT +: DBIT]; stable while `req[i]`=1.
- `lock`  in  NREQ  per-requester frame lock; while the current owner holds its lock high, only that owner may be granted.
- `ack`  out  NREQ  one-hot, 1-cycle pulse: byte of requester i accepted.
- `tx_start`  out  1  1-cycle start pulse to the transmitter.
- `tx_din`  out  DBIT  byte to the transmitter; valid in the `tx_start` cycle and held until the next start.
- `tx_done_tick`  in  1  1-cycle completion pulse from the transmitter.
- `busy`  out  1  high from `tx_start` through the cycle `tx_done_tick` is seen.
- `owner`  out  IDW  index of the last granted requester.

## Operation
- States: IDLE, SEND, WAIT.
- **IDLE:**
  - Eligible set: if `owner_locked`, only `req[owner]`; otherwise all of `req`.
  - Choose the first eligible index, searching circularly from `rr_ptr`.
  - On a winner: register `tx_din` ← that requester's `din` slice, `owner` ← index, set `rr_ptr` ← (index+1) mod NREQ, and go to SEND.
  - No eligible request: stay in IDLE.
- **SEND:**
  - `tx_start`=1, `ack[owner]`=1, `busy`=1, for exactly one cycle.
  - Go to WAIT.
- **WAIT:**
  - `busy`=1; ignore `req`.
  - On `tx_done_tick`, go to IDLE and latch `owner_locked` ← `lock[owner]`.
  - `busy` drops on the following cycle.
- Lock:
  - `owner_locked` is also cleared in IDLE whenever `lock[owner]`=0.
  - A locked owner with `req` low stalls the arbiter; other requesters wait. This is intended behaviour, so frames stay contiguous.
- Requester rules:
  - A requester drops `req`, or presents its next byte, in the cycle after `ack`.
  - Because the arbiter is in WAIT, a `req` still high during `ack` is never double-counted.
  - A `req` withdrawn before the IDLE sample cycle is not served.
- A `tx_done_tick` arriving outside WAIT is ignored.
- Arithmetic: the `rr_ptr` increment wraps modulo NREQ (NREQ-1 → 0).

## Timing
- Reset (asynchronous, immediate): state=IDLE, `ack`=0, `tx_start`=0, `tx_din`=0, `busy`=0, `owner`=0, `rr_ptr`=0, `owner_locked`=0.
- Reset mid-transfer abandons the byte and sends no `ack`. The transmitter shares `reset`.
- Latency, arbiter idle: `req` high at edge N (sampled in IDLE) → `ack` and `tx_start` high during cycle N+1.
- Back-to-back: `tx_done_tick` at cycle T → IDLE at T+1 → next `tx_start` at T+2. This gives a minimum 2-cycle gap between a done pulse and the next start.
- Throughput: one byte per transmitter frame plus 2 clocks.
- Simultaneous requests: priority after reset is 0,1,…,NREQ-1; thereafter it starts at last grant+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then single request: `req`=0001, `din[7:0]`=0xA5 → `ack`=0001 and `tx_start` one cycle later with `tx_din`=0xA5. The serial line shows start bit, 1,0,1,0,0,1,0,1 (LSB first), stop bit, then `busy` low.
- Round-robin fairness: all four `req` held high continuously, `lock`=0 → grant order 0,1,2,3,0,… with exactly one `ack` per frame.
- Frame lock: requester 2 sends 3 bytes with `lock[2]` high while requesters 0 and 3 also request → three consecutive grants to 2. After `lock[2]` drops, the next grant is 3, then 0.
- Withdrawn request: `req[1]` pulses high for one cycle while the arbiter is in WAIT → no `ack[1]`, no extra `tx_start`.
- Reset mid-frame: assert `reset` during the data bits → `tx_start`, `ack`, `busy` go to 0 immediately. After release, `req`=1000 → first grant is requester 3 within 1 cycle.
- Wrap and back-to-back timing: owner=3 with only `req[0]` pending → next grant to 0. Measure exactly 2 cycles from `tx_done_tick` to `tx_start`.
